// File: rtl/instruction_fetch_unit.sv
// IF stage of a 5-stage MIPS pipeline. Owns the PC, runs the instruction-memory
// request/response handshake and loads the IF/ID register, honouring hazard-unit stalls and ID redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid
);

    localparam logic [0:0]  ST_FETCH = 1'b0;
    localparam logic [0:0]  ST_HOLD  = 1'b1;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic [0:0]  state,       state_nxt;
    logic [31:0] pc,          pc_nxt;
    logic        squash,      squash_nxt;
    logic [31:0] redirect_pc, redirect_pc_nxt;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        capture_hold;

    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;

    logic        advance;
    logic        redirect;
    logic [31:0] pc_plus4;

    // A branch that is itself stalled in ID must not steer fetch.
    assign advance  = PC_Write & IF_ID_Write;
    assign redirect = branch_taken & IF_ID_Write;
    assign pc_plus4 = pc + 32'd4;

    assign imem_req  = (state == ST_FETCH) && !rst;
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt       = state;
        pc_nxt          = pc;
        squash_nxt      = squash;
        redirect_pc_nxt = redirect_pc;
        instr_nxt       = IF_ID_instr;
        pc4_nxt         = IF_ID_pc4;
        valid_nxt       = IF_ID_valid;
        capture_hold    = 1'b0;

        case (state)
            ST_FETCH: begin
                if (redirect || (squash && imem_ready)) begin
                    // The response in flight belongs to the wrong path.
                    if (imem_ready) begin
                        pc_nxt     = redirect ? branch_target : redirect_pc;
                        squash_nxt = 1'b0;
                    end else begin
                        redirect_pc_nxt = branch_target;
                        squash_nxt      = 1'b1;
                    end
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                end else if (squash) begin
                    if (IF_ID_Write) begin
                        instr_nxt = NOP;
                        valid_nxt = 1'b0;
                    end
                end else if (imem_ready) begin
                    if (advance) begin
                        instr_nxt = imem_rdata;
                        pc4_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_plus4;
                    end else begin
                        // Memory cannot be asked to hold its data, so park it locally.
                        capture_hold = 1'b1;
                        state_nxt    = ST_HOLD;
                    end
                end else if (IF_ID_Write) begin
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = branch_target;
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                    state_nxt = ST_FETCH;
                end else if (advance) begin
                    instr_nxt = hold_instr;
                    pc4_nxt   = hold_pc4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = ST_FETCH;
                end
            end

            default: state_nxt = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            redirect_pc <= 32'h0000_0000;
            IF_ID_instr <= NOP;
            IF_ID_pc4   <= 32'h0000_0000;
            IF_ID_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            squash      <= squash_nxt;
            redirect_pc <= redirect_pc_nxt;
            IF_ID_instr <= instr_nxt;
            IF_ID_pc4   <= pc4_nxt;
            IF_ID_valid <= valid_nxt;
        end
    end

    // NOTE: the hold buffer is only read in HOLD, which reset never leaves us in, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture_hold) begin
            hold_instr <= imem_rdata;
            hold_pc4   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_holding;
    logic        m_squash;
    logic [31:0] m_redir;
    logic [31:0] m_buf;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc4     (IF_ID_pc4),
        .IF_ID_valid   (IF_ID_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: never zero, so a real instruction differs from a bubble.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic set_inputs(input logic r, input logic pw, input logic iw,
                              input logic bt, input logic [31:0] tgt, input logic rdy);
        rst           = r;
        PC_Write      = pw;
        IF_ID_Write   = iw;
        branch_taken  = bt;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = rdy ? mem_word(imem_addr) : $urandom;
        #1;
    endtask

    // Advance the model by one cycle from the present inputs, then clock the DUT.
    task automatic tick();
        logic adv, redir;
        logic [31:0] fetched;
        adv     = PC_Write & IF_ID_Write;
        redir   = branch_taken & IF_ID_Write;
        fetched = mem_word(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_holding = 1'b0; m_squash = 1'b0; m_redir = 32'h0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_holding) begin
            if (redir) begin
                m_pc = branch_target; m_holding = 1'b0; m_instr = 32'h0; m_valid = 1'b0;
            end else if (adv) begin
                m_instr = m_buf; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_holding = 1'b0;
            end
        end else if (redir && imem_ready) begin
            m_pc = branch_target; m_squash = 1'b0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (redir) begin
            m_redir = branch_target; m_squash = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
        end else if (m_squash && imem_ready) begin
            m_pc = m_redir; m_squash = 1'b0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (imem_ready && !m_squash) begin
            if (adv) begin
                m_instr = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
                m_buf = fetched; m_holding = 1'b1;
            end
        end else if (IF_ID_Write) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        compared++;
        if (imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_req: imem_req=%b expected 0", imem_req);
        end
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {32'h0, 32'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_ifid: instr=%h pc4=%h valid=%b expected 0/0/0",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid);
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            mismatched++;
            $display("FAIL reset_first_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            compared++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
                mismatched++;
                $display("FAIL zero_wait_addr[%0d]: req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, 4 * i);
            end
            tick();
            compared++;
            if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'(4 * i)), 32'(4 * i + 4), 1'b1}) begin
                mismatched++;
                $display("FAIL zero_wait_ifid[%0d]: instr=%h pc4=%h valid=%b expected %h/%h/1",
                         i, IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'(4 * i)), 4 * i + 4);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        fetch_n(2);
        for (int i = 0; i < 2; i++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            compared++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
                mismatched++;
                $display("FAIL wait_addr[%0d]: req=%b addr=%h expected 1/00000008", i, imem_req, imem_addr);
            end
            tick();
            compared++;
            if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {32'h0, 32'h8, 1'b0}) begin
                mismatched++;
                $display("FAIL wait_bubble[%0d]: instr=%h pc4=%h valid=%b expected 0/00000008/0",
                         i, IF_ID_instr, IF_ID_pc4, IF_ID_valid);
            end
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'h8), 32'hC, 1'b1}) begin
            mismatched++;
            $display("FAIL wait_deliver: instr=%h pc4=%h valid=%b expected %h/0000000c/1",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'h8));
        end
    endtask

    task automatic test_load_use_stall();
        do_reset();
        fetch_n(4);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_inputs(1'b0, i == 0 ? 1'b0 : 1'b1, i == 0 ? 1'b0 : 1'b1, 1'b0, 32'h0, 1'b0);
            compared++;
            if ({imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {1'b0, mem_word(32'hC), 32'h10, 1'b1}) begin
                mismatched++;
                $display("FAIL stall_hold[%0d]: req=%b instr=%h pc4=%h valid=%b expected 0/%h/00000010/1",
                         i, imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'hC));
            end
            tick();
        end
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'h10), 32'h14, 1'b1}) begin
            mismatched++;
            $display("FAIL stall_release: instr=%h pc4=%h valid=%b expected %h/00000014/1",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'h10));
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h14}) begin
            mismatched++;
            $display("FAIL stall_next_req: req=%b addr=%h expected 1/00000014", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect_zero_wait();
        do_reset();
        fetch_n(2);
        set_inputs(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {32'h0, 32'h8, 1'b0}) begin
            mismatched++;
            $display("FAIL redir_flush: instr=%h pc4=%h valid=%b expected 0/00000008/0",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid);
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            mismatched++;
            $display("FAIL redir_target: req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect_during_wait();
        do_reset();
        fetch_n(8);
        set_inputs(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        tick();
        set_inputs(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        compared++;
        if ({imem_addr, IF_ID_valid} !== {32'h20, 1'b0}) begin
            mismatched++;
            $display("FAIL redir_wait_hold: addr=%h valid=%b expected 00000020/0", imem_addr, IF_ID_valid);
        end
        tick();
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_valid} !== {32'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL redir_wait_drop: instr=%h valid=%b expected 0/0", IF_ID_instr, IF_ID_valid);
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
            mismatched++;
            $display("FAIL redir_wait_latest: req=%b addr=%h expected 1/00000300", imem_req, imem_addr);
        end
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'h300), 32'h304, 1'b1}) begin
            mismatched++;
            $display("FAIL redir_wait_deliver: instr=%h pc4=%h valid=%b expected %h/00000304/1",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'h300));
        end
    endtask

    task automatic test_stalled_branch_ignored();
        do_reset();
        fetch_n(1);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'h0), 32'h4, 1'b1}) begin
            mismatched++;
            $display("FAIL stalled_branch_ifid: instr=%h pc4=%h valid=%b expected %h/00000004/1",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'h0));
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if (imem_addr !== 32'h4) begin
            mismatched++;
            $display("FAIL stalled_branch_pc: addr=%h expected 00000004", imem_addr);
        end
        tick();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        fetch_n(1);
        set_inputs(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        fetch_n(1);
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {mem_word(32'hFFFF_FFFC), 32'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL wrap_ifid: instr=%h pc4=%h valid=%b expected %h/00000000/1",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid, mem_word(32'hFFFF_FFFC));
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if (imem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL wrap_addr: addr=%h expected 00000000", imem_addr);
        end
        tick();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        fetch_n(1);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        compared++;
        if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {32'h0, 32'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL hold_reset_ifid: instr=%h pc4=%h valid=%b expected 0/0/0",
                     IF_ID_instr, IF_ID_pc4, IF_ID_valid);
        end
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            mismatched++;
            $display("FAIL hold_reset_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_random();
        logic r, pw, iw, bt, rdy, want_req;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 7) == 0);
            want_req = !r && !m_holding;
            rdy = want_req && ($urandom_range(0, 1) == 1);
            set_inputs(r, pw, iw, bt, $urandom & 32'hFFFF_FFFC, rdy);
            compared++;
            if ({imem_req, want_req ? imem_addr : 32'h0} !== {want_req, want_req ? m_pc : 32'h0}) begin
                mismatched++;
                $display("FAIL random_req[%0d]: req=%b addr=%h expected %b/%h", i, imem_req, imem_addr, want_req, m_pc);
            end
            tick();
            compared++;
            if ({IF_ID_instr, IF_ID_pc4, IF_ID_valid} !== {m_instr, m_pc4, m_valid}) begin
                mismatched++;
                $display("FAIL random_ifid[%0d]: instr=%h pc4=%h valid=%b expected %h/%h/%b",
                         i, IF_ID_instr, IF_ID_pc4, IF_ID_valid, m_instr, m_pc4, m_valid);
            end
        end
    endtask

    initial begin
        m_pc = 32'h0; m_holding = 1'b0; m_squash = 1'b0; m_redir = 32'h0;
        m_buf = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        set_inputs(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_load_use_stall();
        test_redirect_zero_wait();
        test_redirect_during_wait();
        test_stalled_branch_ignored();
        test_pc_wrap();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

IF stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory request/response handshake and loads the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes that unit's PC_Write / IF_ID_Write stall controls, plus the branch redirect resolved in ID. Variable-latency instruction memory is supported: the stage inserts bubbles while waiting and discards in-flight responses made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- PC_Write  in  1  from hazard unit; 0 freezes PC
- IF_ID_Write  in  1  from hazard unit; 0 freezes IF/ID
- branch_taken  in  1  redirect request from ID stage
- branch_target  in  32  redirect address (word aligned)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, = current PC
- imem_ready  in  1  response valid this cycle (may be same cycle as request)
- imem_rdata  in  32  instruction, valid when imem_ready=1
- IF_ID_instr  out  32  instruction to ID
- IF_ID_pc4  out  32  PC+4 of that instruction
- IF_ID_valid  out  1  0 = bubble

## Operation
- advance = PC_Write & IF_ID_Write; redirect = branch_taken & IF_ID_Write (branch stalled in ID is ignored).
- Registers: pc, state {FETCH, HOLD}, squash, redirect_pc, hold_instr, hold_pc4.
- FETCH: imem_req=1, imem_addr=pc; address stays stable until imem_ready.
  - redirect, imem_ready=1 (or squash=1 and imem_ready=1): drop response; pc<=redirect target (branch_target if redirect this cycle, else redirect_pc); squash<=0; IF/ID flushed.
  - redirect, imem_ready=0: redirect_pc<=branch_target, squash<=1; IF/ID flushed; pc unchanged.
  - squash=1, no redirect, imem_ready=0: wait; IF/ID gets bubble if IF_ID_Write.
  - no redirect/squash, imem_ready=1, advance: IF/ID<={rdata, pc+4, 1}; pc<=pc+4.
  - no redirect/squash, imem_ready=1, !advance: hold_instr<=rdata, hold_pc4<=pc+4; state<=HOLD; IF/ID unchanged.
  - imem_ready=0, IF_ID_Write=1: IF/ID<=bubble.
- HOLD: imem_req=0. advance: IF/ID<={hold_instr, hold_pc4, 1}; pc<=pc+4; state<=FETCH. redirect cannot occur without IF_ID_Write=1; if redirect: buffer dropped, IF/ID flushed, pc<=branch_target, state<=FETCH. Otherwise hold.
- Flush/bubble = IF_ID_instr 32'h0 (sll NOP), IF_ID_valid 0, IF_ID_pc4 unchanged.
- Priority: rst > redirect > squash drop > stall > normal advance. A second redirect while squash=1 overwrites redirect_pc (latest wins).
- PC arithmetic 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000; bits [1:0] never modified.

## Timing
- Reset (any state, mid-handshake included): pc=RESET_PC, state=FETCH, squash=0, redirect_pc=0, IF_ID_instr=0, IF_ID_pc4=0, IF_ID_valid=0; imem_req forced 0 while rst=1. Pending response arriving after reset is treated as response to RESET_PC request only if imem_ready occurs after the request is issued; memory is required to cancel on rst.
- First request: cycle after rst deasserts, imem_addr=RESET_PC.
- Latency: instruction visible on IF_ID_* at the edge where imem_ready=1 was sampled; zero-wait memory gives 1 instr/cycle.
- Redirect: flush at same edge; target request next cycle (zero-wait) or after stale response drains.
- Stall release from HOLD: buffered instruction at IF/ID at the first edge with advance=1; new request next cycle.

## Test plan
- Reset, zero-wait memory: imem_addr 0x0,0x4,0x8 on consecutive cycles; IF_ID_pc4 0x4,0x8,0xC, valid 1 each edge.
- Wait states: imem_ready low 2 cycles at addr 0x8 -> imem_addr held 0x8, IF_ID_valid 0 two edges, then instr with pc4 0xC.
- Load-use stall: PC_Write=IF_ID_Write=0 for 2 cycles as response for 0x10 arrives -> HOLD, imem_req 0, IF/ID unchanged; on release IF_ID_pc4=0x14, next imem_addr 0x14.
- Redirect zero-wait: branch_taken, target 0x100 -> next edge IF_ID_valid 0, instr 0; next imem_addr 0x100.
- Redirect during wait: request 0x20 pending, branch to 0x200 then 0x300 before ready -> response dropped (valid 0), next imem_addr 0x300.
- branch_taken with IF_ID_Write=0 ignored (pc unchanged, no flush); rst asserted in HOLD -> next request at RESET_PC, IF_ID_valid 0.
